// File: rtl/dac_tx_framer.sv
// DAC transmit framer: sample-pair FIFO feeding an IDLE -> SYNC -> RUN framer for an ODDR word pair.
// Define DAC_TX_PATTERN_EN to build the optional ramp test-pattern generator (pattern_sel).
module dac_tx_framer #(
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_CYCLES = 16,
  parameter int FRAME_PAIRS = 8
) (
  input  logic        sys_clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [23:0] s_data,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic        pattern_sel,
  input  logic        underflow_clr,
  output logic [11:0] tx_d1,
  output logic [11:0] tx_d2,
  output logic        tx_strobe,
  output logic        tx_active,
  output logic        underflow
);
  localparam int AW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int SCW = $clog2(SYNC_CYCLES + 1);
  localparam int FCW = $clog2(FRAME_PAIRS);

  localparam logic [AW:0]    DEPTH_C    = (AW+1)'(FIFO_DEPTH);
  localparam logic [SCW-1:0] SYNC_LAST  = SCW'(SYNC_CYCLES - 1);
  localparam logic [FCW-1:0] FRAME_LAST = FCW'(FRAME_PAIRS - 1);

  localparam logic [11:0] MIDSCALE = 12'h800;
  localparam logic [11:0] SYNC_W1  = 12'hAAA;
  localparam logic [11:0] SYNC_W2  = 12'h555;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SYNC = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;

  logic [1:0]     state, state_nx;
  logic [SCW-1:0] sync_cnt;
  logic [FCW-1:0] frame_cnt;
  logic [23:0]    mem [FIFO_DEPTH];
  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic [AW:0]    count, count_nx;
  logic [23:0]    head;
  logic [11:0]    run_d1, run_d2;
  logic           run_out, enter_sync, pat_mode, push, pop, uf_set;

`ifdef DAC_TX_PATTERN_EN
  logic [11:0] ramp;
  assign pat_mode = pattern_sel;
`else
  logic unused_pattern_sel;
  assign unused_pattern_sel = pattern_sel;
  assign pat_mode = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (enable) state_nx = ST_SYNC;
      ST_SYNC: begin
        if (!enable)                    state_nx = ST_IDLE;
        else if (sync_cnt == SYNC_LAST) state_nx = ST_RUN;
      end
      ST_RUN:  if (!enable) state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // Outputs are registered from the state being entered, so the first RUN
  // cycle already carries a popped pair and the frame strobe.
  assign enter_sync = (state == ST_IDLE) && (state_nx == ST_SYNC);
  assign run_out    = (state_nx == ST_RUN);
  assign push       = s_valid && s_ready && (state_nx != ST_IDLE);
  assign pop        = run_out && !pat_mode && (count != '0);
  assign uf_set     = run_out && !pat_mode && (count == '0);
  assign head       = mem[rd_ptr];

  always_comb begin
    count_nx = count;
    if (state_nx == ST_IDLE)  count_nx = '0;
    else if (push && !pop)    count_nx = count + 1'b1;
    else if (pop && !push)    count_nx = count - 1'b1;
  end

  always_comb begin
    run_d1 = MIDSCALE;
    run_d2 = MIDSCALE;
    if (pop) begin
      run_d1 = head[11:0];
      run_d2 = head[23:12];
    end
`ifdef DAC_TX_PATTERN_EN
    if (pat_mode) begin
      run_d1 = ramp;
      run_d2 = ramp + 12'd1;
    end
`endif
  end

  always_ff @(posedge sys_clk) begin
    if (push) mem[wr_ptr] <= s_data;
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      sync_cnt  <= '0;
      frame_cnt <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      s_ready   <= 1'b0;
      tx_d1     <= MIDSCALE;
      tx_d2     <= MIDSCALE;
      tx_strobe <= 1'b0;
      tx_active <= 1'b0;
      underflow <= 1'b0;
    end else begin
      state     <= state_nx;
      count     <= count_nx;
      // Ready looks only at next occupancy, never at a same-cycle pop.
      s_ready   <= (state_nx != ST_IDLE) && (count_nx != DEPTH_C);
      tx_active <= run_out;
      tx_strobe <= run_out && (frame_cnt == '0);
      sync_cnt  <= (state == ST_SYNC && state_nx == ST_SYNC) ? sync_cnt + 1'b1 : '0;
      frame_cnt <= (!run_out || frame_cnt == FRAME_LAST) ? '0 : frame_cnt + 1'b1;

      if (state_nx == ST_IDLE) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
      end

      if (enter_sync)         underflow <= 1'b0;
      else if (uf_set)        underflow <= 1'b1;
      else if (underflow_clr) underflow <= 1'b0;

      case (state_nx)
        ST_SYNC: begin
          tx_d1 <= SYNC_W1;
          tx_d2 <= SYNC_W2;
        end
        ST_RUN: begin
          tx_d1 <= run_d1;
          tx_d2 <= run_d2;
        end
        default: begin
          tx_d1 <= MIDSCALE;
          tx_d2 <= MIDSCALE;
        end
      endcase
    end
  end

`ifdef DAC_TX_PATTERN_EN
  always_ff @(posedge sys_clk) begin
    if (rst || enter_sync)      ramp <= '0;
    else if (run_out && pat_mode) ramp <= ramp + 12'd2;
  end
`endif

endmodule

// File: tb/tb_dac_tx_framer.sv
// Bench for dac_tx_framer: reset/preamble vector table, hand sequences for the
// multi-cycle corners, and a negedge scoreboard that tracks every accepted pair.
module tb_dac_tx_framer;
  localparam int FD = 4;
  localparam int SC = 16;
  localparam int FP = 8;

  logic        sys_clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic [23:0] s_data = '0;
  logic        s_valid = 1'b0;
  logic        pattern_sel = 1'b0;
  logic        underflow_clr = 1'b0;
  logic        s_ready, tx_strobe, tx_active, underflow;
  logic [11:0] tx_d1, tx_d2;

  int checks = 0;
  int failures = 0;
  int n_acc = 0;
  int pair_n = 0;
  int run_idx = 0;
  bit pat_last = 1'b0;
  logic [23:0] sbq[$];

  always #4 sys_clk = ~sys_clk;

  dac_tx_framer #(.FIFO_DEPTH(FD), .SYNC_CYCLES(SC), .FRAME_PAIRS(FP)) dut (
    .sys_clk(sys_clk), .rst(rst), .enable(enable),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .pattern_sel(pattern_sel), .underflow_clr(underflow_clr),
    .tx_d1(tx_d1), .tx_d2(tx_d2), .tx_strobe(tx_strobe),
    .tx_active(tx_active), .underflow(underflow)
  );

  task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  function automatic logic [23:0] mkpair(input int n);
    return {12'h200 + 12'(n), 12'h100 + 12'(n)};
  endfunction

  // One cycle; present the next pair only once the current one was taken.
  task automatic step();
    logic acc;
    acc = s_valid && s_ready && enable && !rst;
    tick();
    if (acc) begin
      pair_n++;
      s_data = mkpair(pair_n);
    end
  endtask

  task automatic restart_fill(input int run_cycles);
    int a0;
    enable = 1'b0;
    tick();
    pair_n++;
    s_data  = mkpair(pair_n);
    s_valid = 1'b1;
    enable  = 1'b1;
    a0 = n_acc;
    repeat (SC) step();
    chk("sync_fill", 48'(n_acc - a0), 48'(FD));
    chk("sync_full_rdy", 48'(s_ready), 48'(0));
    repeat (run_cycles) step();
  endtask

  // Scoreboard: compare the pair emitted on the last edge, then log what the next edge accepts.
  always @(negedge sys_clk) begin
    bit pat_now;
    logic [23:0] e;
`ifdef DAC_TX_PATTERN_EN
    pat_now = pat_last;
`else
    pat_now = 1'b0;
`endif
    chk("strobe", 48'(tx_strobe), 48'(tx_active && (run_idx % FP == 0)));
    run_idx = tx_active ? run_idx + 1 : 0;
    if (tx_active && !pat_now && !(tx_d1 == 12'h800 && tx_d2 == 12'h800)) begin
      if (sbq.size() == 0) chk("sb_extra", 48'({tx_d2, tx_d1}), 48'(24'h800800));
      else begin
        e = sbq.pop_front();
        chk("sb_data", 48'({tx_d2, tx_d1}), 48'(e));
      end
    end
    if (rst || !enable) sbq.delete();
    else if (s_valid && s_ready) begin
      sbq.push_back(s_data);
      n_acc++;
    end
    pat_last = pattern_sel;
  end

  typedef struct {
    logic        rst, en;
    logic [11:0] d1, d2;
    logic        act, stb, rdy, uf;
  } vec_t;
  vec_t tv[21];

  initial begin
    tv[0]  = '{1'b1, 1'b0, 12'h800, 12'h800, 1'b0, 1'b0, 1'b0, 1'b0};
    tv[1]  = '{1'b1, 1'b1, 12'h800, 12'h800, 1'b0, 1'b0, 1'b0, 1'b0};
    tv[2]  = '{1'b0, 1'b0, 12'h800, 12'h800, 1'b0, 1'b0, 1'b0, 1'b0};
    for (int i = 3; i < 3 + SC; i++)
      tv[i] = '{1'b0, 1'b1, 12'hAAA, 12'h555, 1'b0, 1'b0, 1'b1, 1'b0};
    tv[19] = '{1'b0, 1'b1, 12'h800, 12'h800, 1'b1, 1'b1, 1'b1, 1'b1};
    tv[20] = '{1'b0, 1'b1, 12'h800, 12'h800, 1'b1, 1'b0, 1'b1, 1'b1};

    for (int i = 0; i < 21; i++) begin
      rst    = tv[i].rst;
      enable = tv[i].en;
      tick();
      chk($sformatf("vec%0d", i),
          48'({tx_d1, tx_d2, tx_active, tx_strobe, s_ready, underflow}),
          48'({tv[i].d1, tv[i].d2, tv[i].act, tv[i].stb, tv[i].rdy, tv[i].uf}));
    end

    // Restart: underflow survives IDLE, clears on SYNC entry; then latency and order.
    enable = 1'b0;
    tick();
    chk("idle_uf_hold", 48'(underflow), 48'(1));
    chk("idle_out", 48'({tx_d1, tx_d2, tx_active, s_ready}), 48'({12'h800, 12'h800, 2'b00}));
    enable = 1'b1;
    tick();
    chk("sync_uf_clr", 48'(underflow), 48'(0));
    repeat (SC - 1) tick();
    chk("sync_last", 48'({tx_d1, tx_d2, tx_active}), 48'({12'hAAA, 12'h555, 1'b0}));
    tick();
    chk("run_entry", 48'({tx_active, tx_strobe}), 48'(2'b11));
    s_valid = 1'b1;
    s_data  = {12'h002, 12'h001};
    tick();
    chk("lat_k", 48'({tx_d1, tx_d2}), 48'({12'h800, 12'h800}));
    s_data = {12'h004, 12'h003};
    tick();
    chk("lat_k1", 48'({tx_d1, tx_d2}), 48'({12'h001, 12'h002}));
    s_data = {12'h006, 12'h005};
    tick();
    chk("order2", 48'({tx_d1, tx_d2}), 48'({12'h003, 12'h004}));
    s_valid = 1'b0;
    tick();
    chk("order3", 48'({tx_d1, tx_d2}), 48'({12'h005, 12'h006}));
    tick();
    chk("drain_uf", 48'({tx_d1, tx_d2, underflow}), 48'({12'h800, 12'h800, 1'b1}));
    repeat (6) tick();

    // Backpressure in SYNC, streaming in RUN, full drain.
    restart_fill(12);
    s_valid = 1'b0;
    repeat (6) tick();
    chk("drained", 48'(sbq.size()), 48'(0));
    chk("stream_uf", 48'(underflow), 48'(1));

    // Underflow: coincident set beats clear; clear works on a non-empty cycle.
    underflow_clr = 1'b1;
    tick();
    chk("uf_set_wins", 48'(underflow), 48'(1));
    underflow_clr = 1'b0;
    s_valid = 1'b1;
    s_data  = {12'h0BB, 12'h0AA};
    tick();
    s_valid = 1'b0;
    underflow_clr = 1'b1;
    tick();
    chk("uf_clr", 48'({underflow, tx_d1, tx_d2}), 48'({1'b0, 12'h0AA, 12'h0BB}));
    underflow_clr = 1'b0;
    tick();
    chk("uf_reset", 48'(underflow), 48'(1));
    repeat (3) tick();
    chk("uf_sticky", 48'(underflow), 48'(1));

    // Drop enable with data in flight: flush, then a clean preamble.
    restart_fill(5);
    enable = 1'b0;
    tick();
    chk("flush_idle", 48'({tx_d1, tx_d2, tx_active, s_ready, tx_strobe}),
        48'({12'h800, 12'h800, 3'b000}));
    s_valid = 1'b0;
    enable  = 1'b1;
    tick();
    chk("resync", 48'({tx_d1, tx_d2, s_ready, underflow}), 48'({12'hAAA, 12'h555, 2'b10}));
    repeat (SC - 1) tick();
    tick();
    chk("resync_run", 48'({tx_d1, tx_d2, tx_active, underflow}), 48'({12'h800, 12'h800, 2'b11}));

`ifdef DAC_TX_PATTERN_EN
    pattern_sel = 1'b1;
    enable = 1'b0;
    tick();
    pair_n++;
    s_data  = mkpair(pair_n);
    s_valid = 1'b1;
    enable  = 1'b1;
    repeat (SC) step();
    for (int i = 0; i < 2050; i++) begin
      logic [11:0] r;
      r = 12'(2 * i);
      step();
      chk("pattern", 48'({tx_d1, tx_d2, underflow}), 48'({r, r + 12'd1, 1'b0}));
    end
    chk("pat_full", 48'(s_ready), 48'(0));
    pattern_sel = 1'b0;
    s_valid = 1'b0;
    repeat (6) tick();
    chk("pat_drain", 48'(sbq.size()), 48'(0));
`else
    pattern_sel = 1'b1;
    s_valid = 1'b1;
    s_data  = {12'h3C4, 12'h3C3};
    tick();
    s_valid = 1'b0;
    tick();
    chk("nopat_data", 48'({tx_d1, tx_d2}), 48'({12'h3C3, 12'h3C4}));
    pattern_sel = 1'b0;
    tick();
`endif

    // Reset in mid-RUN discards FIFO contents.
    restart_fill(3);
    rst = 1'b1;
    tick();
    chk("rst_mid", 48'({tx_d1, tx_d2, tx_active, tx_strobe, s_ready, underflow}),
        48'({12'h800, 12'h800, 4'b0000}));
    rst = 1'b0;
    s_valid = 1'b0;
    repeat (SC) tick();
    chk("post_rst_sync", 48'({tx_d1, tx_d2, tx_active}), 48'({12'hAAA, 12'h555, 1'b0}));
    tick();
    chk("post_rst_run", 48'({tx_d1, tx_d2, tx_active}), 48'({12'h800, 12'h800, 1'b1}));
    repeat (3) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
